// File: rtl/dvs_ramp_ctrl_if.sv
// Write/fault/status bundle between the register path and the DVS ramp controller.
interface dvs_ramp_ctrl_if #(
    parameter int unsigned CODE_W = 4
) ();
    logic              en;
    logic [CODE_W-1:0] data;
    logic              wrb;
    logic              ov_dig;
    logic              uv_dig;
    logic [CODE_W-1:0] vref_code;
    logic              dvs_done;
    logic              busy;
    logic              ov_flag;
    logic              uv_flag;
    logic              fault;

    modport master (
        output en, data, wrb, ov_dig, uv_dig,
        input  vref_code, dvs_done, busy, ov_flag, uv_flag, fault
    );

    modport slave (
        input  en, data, wrb, ov_dig, uv_dig,
        output vref_code, dvs_done, busy, ov_flag, uv_flag, fault
    );
endinterface

// File: rtl/dvs_ramp_ctrl.sv
// Slew-limited reference-code ramp with debounced OV/UV fault freeze.
// One-LSB steps every STEP_CYCLES clocks toward the last accepted target.
module dvs_ramp_ctrl #(
    parameter int unsigned CODE_W      = 4,
    parameter int unsigned STEP_CYCLES = 8,
    parameter int unsigned DEB_CYCLES  = 4,
    parameter int unsigned RESET_CODE  = 8
) (
    input  logic           clk,
    input  logic           rst,
    dvs_ramp_ctrl_if.slave bus
);

    localparam int unsigned STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int unsigned DEB_W  = $clog2(DEB_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RAMP  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t              r_state;
    logic [CODE_W-1:0]   r_vref;
    logic [CODE_W-1:0]   r_target;
    logic [STEP_W-1:0]   r_step_cnt;
    logic [DEB_W-1:0]    r_ov_cnt;
    logic [DEB_W-1:0]    r_uv_cnt;
    logic                r_ov_flag;
    logic                r_uv_flag;
    logic                r_fault;
    logic                r_wrb_q;
    logic                r_busy;
    logic                r_done;

    state_t              w_state_nxt;
    logic [CODE_W-1:0]   w_vref_nxt;
    logic [CODE_W-1:0]   w_target_nxt;
    logic [STEP_W-1:0]   w_step_nxt;
    logic [DEB_W-1:0]    w_ov_cnt_nxt;
    logic [DEB_W-1:0]    w_uv_cnt_nxt;
    logic                w_ov_flag_nxt;
    logic                w_uv_flag_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_accept;
    logic                w_ov_set;
    logic                w_uv_set;
    logic                w_fault_set;
    logic [CODE_W-1:0]   w_tgt_eff;
    logic [CODE_W-1:0]   w_stepped;

    // Falling edge of the registered strobe gives one accept per write.
    assign w_accept = bus.en & ~bus.wrb & r_wrb_q;

    // Flags set on the DEB_CYCLES-th consecutive high sample.
    assign w_ov_set = bus.ov_dig & ~r_ov_flag & (r_ov_cnt == DEB_W'(DEB_CYCLES - 1));
    assign w_uv_set = bus.uv_dig & ~r_uv_flag & (r_uv_cnt == DEB_W'(DEB_CYCLES - 1));
    assign w_fault_set = w_ov_set | w_uv_set;

    always_comb begin
        w_state_nxt   = r_state;
        w_vref_nxt    = r_vref;
        w_target_nxt  = r_target;
        w_step_nxt    = r_step_cnt;
        w_busy_nxt    = r_busy;
        w_done_nxt    = r_done;
        w_ov_flag_nxt = r_ov_flag | w_ov_set;
        w_uv_flag_nxt = r_uv_flag | w_uv_set;
        w_tgt_eff     = r_target;
        w_stepped     = r_vref;

        if (!bus.ov_dig)
            w_ov_cnt_nxt = '0;
        else if (r_ov_cnt == DEB_W'(DEB_CYCLES))
            w_ov_cnt_nxt = r_ov_cnt;
        else
            w_ov_cnt_nxt = r_ov_cnt + DEB_W'(1);

        if (!bus.uv_dig)
            w_uv_cnt_nxt = '0;
        else if (r_uv_cnt == DEB_W'(DEB_CYCLES))
            w_uv_cnt_nxt = r_uv_cnt;
        else
            w_uv_cnt_nxt = r_uv_cnt + DEB_W'(1);

        if (!bus.en) begin
            w_ov_cnt_nxt  = '0;
            w_uv_cnt_nxt  = '0;
            w_ov_flag_nxt = 1'b0;
            w_uv_flag_nxt = 1'b0;
            w_target_nxt  = r_vref;
            w_step_nxt    = '0;
            w_state_nxt   = S_IDLE;
            w_busy_nxt    = 1'b0;
            w_done_nxt    = 1'b1;
        end else if (w_fault_set || (r_state == S_FAULT)) begin
            w_state_nxt = S_FAULT;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        w_target_nxt = bus.data;
                        if (bus.data != r_vref) begin
                            w_step_nxt  = '0;
                            w_state_nxt = S_RAMP;
                            w_busy_nxt  = 1'b1;
                            w_done_nxt  = 1'b0;
                        end
                    end
                end
                S_RAMP: begin
                    // A retarget keeps the step phase; direction follows the newest target.
                    w_tgt_eff    = w_accept ? bus.data : r_target;
                    w_target_nxt = w_tgt_eff;
                    if (w_tgt_eff == r_vref) begin
                        w_step_nxt  = '0;
                        w_state_nxt = S_IDLE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else if (r_step_cnt == STEP_W'(STEP_CYCLES - 1)) begin
                        w_step_nxt = '0;
                        w_stepped  = (w_tgt_eff > r_vref) ? (r_vref + CODE_W'(1))
                                                          : (r_vref - CODE_W'(1));
                        w_vref_nxt = w_stepped;
                        if (w_stepped == w_tgt_eff) begin
                            w_state_nxt = S_IDLE;
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                        end
                    end else begin
                        w_step_nxt = r_step_cnt + STEP_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = (r_vref == r_target);
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_vref     <= CODE_W'(RESET_CODE);
            r_target   <= CODE_W'(RESET_CODE);
            r_step_cnt <= '0;
            r_ov_cnt   <= '0;
            r_uv_cnt   <= '0;
            r_ov_flag  <= 1'b0;
            r_uv_flag  <= 1'b0;
            r_fault    <= 1'b0;
            r_wrb_q    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_vref     <= w_vref_nxt;
            r_target   <= w_target_nxt;
            r_step_cnt <= w_step_nxt;
            r_ov_cnt   <= w_ov_cnt_nxt;
            r_uv_cnt   <= w_uv_cnt_nxt;
            r_ov_flag  <= w_ov_flag_nxt;
            r_uv_flag  <= w_uv_flag_nxt;
            r_fault    <= w_ov_flag_nxt | w_uv_flag_nxt;
            r_wrb_q    <= bus.wrb;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign bus.vref_code = r_vref;
    assign bus.dvs_done  = r_done;
    assign bus.busy      = r_busy;
    assign bus.ov_flag   = r_ov_flag;
    assign bus.uv_flag   = r_uv_flag;
    assign bus.fault     = r_fault;

endmodule

// File: tb/tb_dvs_ramp_ctrl.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, a negedge monitor checks them.
module tb_dvs_ramp_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    dvs_ramp_ctrl_if #(.CODE_W(4)) u_if ();

    dvs_ramp_ctrl #(
        .CODE_W(4), .STEP_CYCLES(8), .DEB_CYCLES(4), .RESET_CODE(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        string      name;
        logic [3:0] code;
        logic       done;
        logic       busy;
        logic       ov;
        logic       uv;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_at(input int ofs, input string name, input logic [3:0] code,
                             input logic done, input logic busy, input logic ov, input logic uv);
        exp_t e;
        e.cyc = cyc + ofs; e.name = name; e.code = code;
        e.done = done; e.busy = busy; e.ov = ov; e.uv = uv;
        q.push_back(e);
    endtask

    task automatic write_code(input logic [3:0] d);
        u_if.data = d;
        u_if.wrb  = 1'b0;
        tick(1);
        u_if.wrb  = 1'b1;
    endtask

    // Monitor: pops every expectation due at this cycle and compares all outputs.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e_mon = q.pop_front();
            checks++;
            if (e_mon.cyc < cyc) begin
                failures++;
                $display("FAIL %s: missed sample, due cyc=%0d now cyc=%0d", e_mon.name, e_mon.cyc, cyc);
            end else if (u_if.vref_code !== e_mon.code || u_if.dvs_done !== e_mon.done ||
                         u_if.busy !== e_mon.busy || u_if.ov_flag !== e_mon.ov ||
                         u_if.uv_flag !== e_mon.uv || u_if.fault !== (e_mon.ov | e_mon.uv)) begin
                failures++;
                $display("FAIL %s cyc=%0d: got code=%0d done=%b busy=%b ov=%b uv=%b fault=%b, want code=%0d done=%b busy=%b ov=%b uv=%b fault=%b",
                         e_mon.name, cyc, u_if.vref_code, u_if.dvs_done, u_if.busy, u_if.ov_flag,
                         u_if.uv_flag, u_if.fault, e_mon.code, e_mon.done, e_mon.busy, e_mon.ov,
                         e_mon.uv, e_mon.ov | e_mon.uv);
            end
        end
    end

    initial begin
        rst = 1'b1;
        u_if.en = 1'b1; u_if.data = 4'd0; u_if.wrb = 1'b1;
        u_if.ov_dig = 1'b0; u_if.uv_dig = 1'b0;
        tick(2);
        rst = 1'b0;
        expect_at(1, "reset", 4'd8, 1, 0, 0, 0);
        tick(2);

        // Down ramp 8 -> 1.
        expect_at(1, "dn_accept", 4'd8, 0, 1, 0, 0);
        expect_at(8, "dn_nostep", 4'd8, 0, 1, 0, 0);
        for (int k = 1; k <= 6; k++) expect_at(1 + 8 * k, "dn_step", 4'(8 - k), 0, 1, 0, 0);
        expect_at(57, "dn_done", 4'd1, 1, 0, 0, 0);
        write_code(4'd1);
        tick(60);

        // Same-code write.
        expect_at(1, "same1", 4'd1, 1, 0, 0, 0);
        expect_at(2, "same1_b", 4'd1, 1, 0, 0, 0);
        write_code(4'd1);
        tick(3);

        // Held strobe: data changes while wrb stays low must not be re-accepted.
        expect_at(1, "hold_acc", 4'd1, 0, 1, 0, 0);
        expect_at(9, "hold_s1", 4'd2, 0, 1, 0, 0);
        expect_at(17, "hold_done", 4'd3, 1, 0, 0, 0);
        expect_at(20, "hold_idle", 4'd3, 1, 0, 0, 0);
        expect_at(28, "hold_one", 4'd3, 1, 0, 0, 0);
        u_if.data = 4'd3; u_if.wrb = 1'b0;
        tick(3);
        u_if.data = 4'd5;
        tick(17);
        u_if.wrb = 1'b1; u_if.data = 4'd0;
        tick(10);

        // Reset while ramping at code 5.
        expect_at(1, "rr_acc", 4'd3, 0, 1, 0, 0);
        expect_at(9, "rr_s1", 4'd4, 0, 1, 0, 0);
        expect_at(17, "rr_s2", 4'd5, 0, 1, 0, 0);
        expect_at(18, "rst_mid", 4'd8, 1, 0, 0, 0);
        expect_at(19, "rst_rel", 4'd8, 1, 0, 0, 0);
        expect_at(27, "rst_noramp", 4'd8, 1, 0, 0, 0);
        write_code(4'd12);
        tick(16);
        #1 rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(10);

        // Same code at 8.
        expect_at(1, "same8", 4'd8, 1, 0, 0, 0);
        expect_at(3, "same8_b", 4'd8, 1, 0, 0, 0);
        write_code(4'd8);
        tick(3);

        // Retarget 8 -> 1, then 12 at code 5 without step-phase reset.
        expect_at(1, "rt_acc1", 4'd8, 0, 1, 0, 0);
        expect_at(9, "rt_s7", 4'd7, 0, 1, 0, 0);
        expect_at(17, "rt_s6", 4'd6, 0, 1, 0, 0);
        expect_at(25, "rt_s5", 4'd5, 0, 1, 0, 0);
        expect_at(28, "rt_acc2", 4'd5, 0, 1, 0, 0);
        expect_at(32, "rt_hold5", 4'd5, 0, 1, 0, 0);
        for (int k = 0; k <= 5; k++) expect_at(33 + 8 * k, "rt_up", 4'(6 + k), 0, 1, 0, 0);
        expect_at(81, "rt_done", 4'd12, 1, 0, 0, 0);
        write_code(4'd1);
        tick(26);
        write_code(4'd12);
        tick(55);

        // Retarget onto the current code ends the ramp on the accept edge.
        expect_at(1, "rq_acc", 4'd12, 0, 1, 0, 0);
        expect_at(9, "rq_s11", 4'd11, 0, 1, 0, 0);
        expect_at(12, "rq_eq", 4'd11, 1, 0, 0, 0);
        expect_at(20, "rq_stay", 4'd11, 1, 0, 0, 0);
        write_code(4'd8);
        tick(10);
        write_code(4'd11);
        tick(10);

        // Three high OV samples do not confirm.
        expect_at(3, "ov3", 4'd11, 1, 0, 0, 0);
        expect_at(5, "ov3_after", 4'd11, 1, 0, 0, 0);
        u_if.ov_dig = 1'b1;
        tick(3);
        u_if.ov_dig = 1'b0;
        tick(5);

        // OV confirmed mid-ramp freezes the code; en low clears.
        expect_at(1, "ov_acc", 4'd11, 0, 1, 0, 0);
        expect_at(9, "ov_s10", 4'd10, 0, 1, 0, 0);
        expect_at(17, "ov_s9", 4'd9, 0, 1, 0, 0);
        expect_at(22, "ov_pre", 4'd9, 0, 1, 0, 0);
        expect_at(23, "ov_set", 4'd9, 0, 0, 1, 0);
        expect_at(25, "ov_frozen", 4'd9, 0, 0, 1, 0);
        expect_at(28, "ov_wr_ign", 4'd9, 0, 0, 1, 0);
        expect_at(40, "ov_sticky", 4'd9, 0, 0, 1, 0);
        expect_at(42, "en_clear", 4'd9, 1, 0, 0, 0);
        expect_at(50, "en_idle", 4'd9, 1, 0, 0, 0);
        write_code(4'd4);
        tick(18);
        u_if.ov_dig = 1'b1;
        tick(4);
        u_if.ov_dig = 1'b0;
        tick(3);
        write_code(4'd2);
        tick(14);
        u_if.en = 1'b0;
        tick(1);
        u_if.en = 1'b1;
        tick(9);

        // UV confirmed on a step edge suppresses that step.
        expect_at(1, "uv_acc", 4'd9, 0, 1, 0, 0);
        expect_at(9, "uv_s10", 4'd10, 0, 1, 0, 0);
        expect_at(17, "uv_s11", 4'd11, 0, 1, 0, 0);
        expect_at(24, "uv_pre", 4'd11, 0, 1, 0, 0);
        expect_at(25, "uv_step", 4'd11, 0, 0, 0, 1);
        expect_at(33, "uv_frozen", 4'd11, 0, 0, 0, 1);
        expect_at(35, "uv_clear", 4'd11, 1, 0, 0, 0);
        write_code(4'd12);
        tick(20);
        u_if.uv_dig = 1'b1;
        tick(4);
        u_if.uv_dig = 1'b0;
        tick(9);
        u_if.en = 1'b0;
        tick(1);
        u_if.en = 1'b1;
        tick(5);

        if (q.size() != 0) begin
            failures++;
            $display("FAIL leftover: %0d expectations never sampled, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
